// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: microop encodings, the per-entry
// payload record and the byte-lane mask helper used for forwarding.
package store_buffer_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_UOP_W  = 5;
  localparam int SB_TKT_W  = 3;

  // Store microops
  localparam logic [SB_UOP_W-1:0] UOP_SW  = 5'b00110;
  localparam logic [SB_UOP_W-1:0] UOP_SH  = 5'b00111;
  localparam logic [SB_UOP_W-1:0] UOP_SB  = 5'b01000;
  // Load microops
  localparam logic [SB_UOP_W-1:0] UOP_LW  = 5'b00001;
  localparam logic [SB_UOP_W-1:0] UOP_LH  = 5'b00010;
  localparam logic [SB_UOP_W-1:0] UOP_LHU = 5'b00011;
  localparam logic [SB_UOP_W-1:0] UOP_LB  = 5'b00100;
  localparam logic [SB_UOP_W-1:0] UOP_LBU = 5'b00101;

  // Payload of one buffered store; valid/committed live in reset-able vectors
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_UOP_W-1:0]  microop;
    logic [SB_TKT_W-1:0]  ticket;
  } sb_entry_t;

  // Byte lanes touched within the 32-bit word; unknown ops touch nothing
  function automatic logic [3:0] mask_of(input logic [SB_UOP_W-1:0] uop,
                                         input logic [1:0] lo);
    logic [3:0] m;
    case (uop)
      UOP_SW, UOP_LW:          m = 4'b1111;
      UOP_SH, UOP_LH, UOP_LHU: m = lo[1] ? 4'b1100 : 4'b0011;
      UOP_SB, UOP_LB, UOP_LBU: m = 4'b0001 << lo;
      default:                 m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_buffer_forward_match.sv
// Youngest-overlap search for store-to-load forwarding. Buffered entries are
// scanned oldest-to-youngest starting at head, then the incoming push, so the
// last overlapping candidate seen wins.
module sb_forward_match
  import store_buffer_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MICROOP    = 5,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]      i_head,
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [ADDR_BITS-1:0]  i_addr [DEPTH],
  input  logic [DATA_WIDTH-1:0] i_data [DEPTH],
  input  logic [MICROOP-1:0]    i_uop  [DEPTH],
  input  logic                  i_push_valid,
  input  logic [ADDR_BITS-1:0]  i_push_addr,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic [MICROOP-1:0]    i_push_uop,
  input  logic [ADDR_BITS-1:0]  i_ld_addr,
  input  logic [MICROOP-1:0]    i_ld_uop,
  output logic                  o_hit,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [3:0]            w_ld_mask;
  logic [3:0]            w_st_mask;
  logic [PTR_W-1:0]      w_idx;
  logic                  w_found;
  logic                  w_exact;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Age-ordered scan; a younger overlapping candidate overrides older ones
  always_comb begin
    w_ld_mask  = mask_of(i_ld_uop, i_ld_addr[1:0]);
    w_st_mask  = 4'b0000;
    w_idx      = '0;
    w_found    = 1'b0;
    w_exact    = 1'b0;
    w_sel_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx     = i_head + PTR_W'(k);
      w_st_mask = mask_of(i_uop[w_idx], i_addr[w_idx][1:0]);
      if (i_valid[w_idx] &&
          (i_addr[w_idx][ADDR_BITS-1:2] == i_ld_addr[ADDR_BITS-1:2]) &&
          ((w_st_mask & w_ld_mask) != 4'b0000)) begin
        w_found    = 1'b1;
        w_exact    = (i_addr[w_idx] == i_ld_addr) &&
                     ((w_st_mask & w_ld_mask) == w_ld_mask);
        w_sel_data = i_data[w_idx];
      end
    end
    w_st_mask = mask_of(i_push_uop, i_push_addr[1:0]);
    if (i_push_valid &&
        (i_push_addr[ADDR_BITS-1:2] == i_ld_addr[ADDR_BITS-1:2]) &&
        ((w_st_mask & w_ld_mask) != 4'b0000)) begin
      w_found    = 1'b1;
      w_exact    = (i_push_addr == i_ld_addr) &&
                   ((w_st_mask & w_ld_mask) == w_ld_mask);
      w_sel_data = i_push_data;
    end
  end

  assign o_hit   = w_found & w_exact;
  assign o_stall = w_found & ~w_exact;
  assign o_data  = (w_found & w_exact) ? w_sel_data : '0;

endmodule

// File: rtl/store_buffer.sv
// Post-execute store queue: holds executed stores until the ROB commits them,
// drains committed stores to the data cache, and forwards to younger loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = SB_DATA_W,
  parameter int ADDR_BITS  = SB_ADDR_W,
  parameter int MICROOP    = SB_UOP_W,
  parameter int ROB_TICKET = SB_TKT_W,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  store_valid,
  input  logic [ADDR_BITS-1:0]  store_address,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [MICROOP-1:0]    store_microop,
  input  logic [ROB_TICKET-1:0] store_ticket,
  output logic                  sb_full,
  input  logic                  commit_valid,
  input  logic [ROB_TICKET-1:0] commit_ticket,
  input  logic                  flush_valid,
  input  logic [ADDR_BITS-1:0]  frw_address,
  input  logic [MICROOP-1:0]    frw_microop,
  output logic [DATA_WIDTH-1:0] frw_data,
  output logic                  frw_valid,
  output logic                  frw_stall,
  output logic                  cache_writeback_valid,
  input  logic                  cache_wb_ready,
  output logic [ADDR_BITS-1:0]  cache_wb_address,
  output logic [DATA_WIDTH-1:0] cache_wb_data,
  output logic [MICROOP-1:0]    cache_wb_microop,
  output logic                  commit_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_cmtd;
  sb_entry_t        r_ent [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail, r_cptr;
  logic [CNT_W-1:0] r_count;   // occupied entries
  logic [CNT_W-1:0] r_ccount;  // committed, not yet drained
  logic             r_err;

  logic             w_full, w_wb_valid, w_drain;
  logic             w_cmt_ok, w_cmt_bad;
  logic             w_push_req, w_push_ok, w_push_drop;
  logic [PTR_W-1:0] w_cptr_nxt;
  logic [CNT_W-1:0] w_ccount_nxt;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_wb_valid  = r_valid[r_head] & r_cmtd[r_head];
  assign w_drain     = w_wb_valid & cache_wb_ready;
  // Commit pointer always names the oldest uncommitted slot when one exists
  assign w_cmt_ok    = commit_valid & r_valid[r_cptr] & ~r_cmtd[r_cptr] &
                       (r_ent[r_cptr].ticket == commit_ticket);
  assign w_cmt_bad   = commit_valid & ~w_cmt_ok;
  assign w_push_req  = store_valid & ~flush_valid;
  assign w_push_ok   = w_push_req & (~w_full | w_drain);
  assign w_push_drop = w_push_req & w_full & ~w_drain;
  assign w_cptr_nxt  = w_cmt_ok ? r_cptr + PTR_W'(1) : r_cptr;
  assign w_ccount_nxt = r_ccount + CNT_W'(w_cmt_ok) - CNT_W'(w_drain);

  // Control state: occupancy flags, pointers, counts and the sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_cmtd   <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_cptr   <= '0;
      r_count  <= '0;
      r_ccount <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_cmtd[r_head]  <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_cmt_ok) r_cmtd[r_cptr] <= 1'b1;
      r_cptr   <= w_cptr_nxt;
      r_ccount <= w_ccount_nxt;
      if (flush_valid) begin
        // Same-cycle commit survives the flush; everything younger is dropped
        for (int i = 0; i < DEPTH; i++) begin
          if (!r_cmtd[i] && !(w_cmt_ok && (r_cptr == PTR_W'(i))))
            r_valid[i] <= 1'b0;
        end
        r_tail  <= w_cptr_nxt;
        r_count <= w_ccount_nxt;
      end else begin
        // Written after the drain clear so a full-buffer push into the freed head slot wins
        if (w_push_ok) begin
          r_valid[r_tail] <= 1'b1;
          r_cmtd[r_tail]  <= 1'b0;
          r_tail          <= r_tail + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_drain);
      end
      if (w_cmt_bad | w_push_drop) r_err <= 1'b1;
    end
  end

  // Entry payload; only meaningful where the matching valid bit is set
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_ent[r_tail] <= '{addr: store_address, data: store_data,
                         microop: store_microop, ticket: store_ticket};
    end
  end

  logic [ADDR_BITS-1:0]  w_addr [DEPTH];
  logic [DATA_WIDTH-1:0] w_data [DEPTH];
  logic [MICROOP-1:0]    w_uop  [DEPTH];

  // Unpack payload fields for the forwarding search
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_addr[k] = r_ent[k].addr;
      w_data[k] = r_ent[k].data;
      w_uop[k]  = r_ent[k].microop;
    end
  end

  sb_forward_match #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH),
    .MICROOP    (MICROOP),
    .DEPTH      (DEPTH)
  ) u_match (
    .i_head       (r_head),
    .i_valid      (r_valid),
    .i_addr       (w_addr),
    .i_data       (w_data),
    .i_uop        (w_uop),
    .i_push_valid (w_push_ok),
    .i_push_addr  (store_address),
    .i_push_data  (store_data),
    .i_push_uop   (store_microop),
    .i_ld_addr    (frw_address),
    .i_ld_uop     (frw_microop),
    .o_hit        (frw_valid),
    .o_stall      (frw_stall),
    .o_data       (frw_data)
  );

  assign sb_full               = w_full;
  assign commit_error          = r_err;
  assign cache_writeback_valid = w_wb_valid;
  assign cache_wb_address      = w_wb_valid ? r_ent[r_head].addr    : '0;
  assign cache_wb_data         = w_wb_valid ? r_ent[r_head].data    : '0;
  assign cache_wb_microop      = w_wb_valid ? r_ent[r_head].microop : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam logic [4:0] SW = 5'b00110, SH = 5'b00111, SB = 5'b01000;
  localparam logic [4:0] LW = 5'b00001, LH = 5'b00010, LB = 5'b00100, LBU = 5'b00101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        store_valid, commit_valid, flush_valid, cache_wb_ready;
  logic [31:0] store_address, store_data, frw_address;
  logic [4:0]  store_microop, frw_microop;
  logic [2:0]  store_ticket, commit_ticket;
  logic        sb_full, frw_valid, frw_stall, cache_writeback_valid, commit_error;
  logic [31:0] frw_data, cache_wb_address, cache_wb_data;
  logic [4:0]  cache_wb_microop;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .store_valid(store_valid), .store_address(store_address), .store_data(store_data),
    .store_microop(store_microop), .store_ticket(store_ticket), .sb_full(sb_full),
    .commit_valid(commit_valid), .commit_ticket(commit_ticket), .flush_valid(flush_valid),
    .frw_address(frw_address), .frw_microop(frw_microop), .frw_data(frw_data),
    .frw_valid(frw_valid), .frw_stall(frw_stall),
    .cache_writeback_valid(cache_writeback_valid), .cache_wb_ready(cache_wb_ready),
    .cache_wb_address(cache_wb_address), .cache_wb_data(cache_wb_data),
    .cache_wb_microop(cache_wb_microop), .commit_error(commit_error)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-ordered list of buffered stores
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  u;
    logic [2:0]  t;
    bit          c;
  } ent_t;

  ent_t q[$];
  bit   m_err;

  function automatic logic [3:0] bmask(input logic [4:0] u, input logic [1:0] a);
    case (u)
      SW, LW:           return 4'hF;
      SH, LH, 5'b00011: return a[1] ? 4'hC : 4'h3;
      SB, LB, LBU:      return 4'b0001 << a;
      default:          return 4'h0;
    endcase
  endfunction

  function automatic bit overlaps(input logic [31:0] sa, input logic [4:0] su);
    return (sa[31:2] == frw_address[31:2]) &&
           ((bmask(su, sa[1:0]) & bmask(frw_microop, frw_address[1:0])) != 4'h0);
  endfunction

  function automatic bit covers(input logic [31:0] sa, input logic [4:0] su);
    logic [3:0] lm;
    lm = bmask(frw_microop, frw_address[1:0]);
    return (sa == frw_address) && ((bmask(su, sa[1:0]) & lm) == lm);
  endfunction

  bit          e_wbv, e_drain, e_pacc, e_found, e_cov;
  logic [31:0] e_fd;
  int          e_j;
  ent_t        e_ent;

  // Every falling edge: predict outputs from the model, compare, then advance it
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
    end
    e_wbv   = (q.size() > 0) && q[0].c;
    e_drain = e_wbv && cache_wb_ready;
    e_pacc  = rst_n && store_valid && !flush_valid && ((q.size() < DEPTH) || e_drain);
    e_found = 1'b0;
    e_cov   = 1'b0;
    e_fd    = 32'h0;
    if (e_pacc && overlaps(store_address, store_microop)) begin
      e_found = 1'b1;
      e_cov   = covers(store_address, store_microop);
      e_fd    = store_data;
    end else begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (overlaps(q[i].a, q[i].u)) begin
          e_found = 1'b1;
          e_cov   = covers(q[i].a, q[i].u);
          e_fd    = q[i].d;
          break;
        end
      end
    end
    chk("sb_full", sb_full, (q.size() == DEPTH));
    chk("wb_valid", cache_writeback_valid, e_wbv);
    chk("wb_address", cache_wb_address, e_wbv ? q[0].a : 32'h0);
    chk("wb_data", cache_wb_data, e_wbv ? q[0].d : 32'h0);
    chk("wb_microop", cache_wb_microop, e_wbv ? q[0].u : 5'h0);
    chk("frw_valid", frw_valid, e_found && e_cov);
    chk("frw_stall", frw_stall, e_found && !e_cov);
    chk("frw_data", frw_data, (e_found && e_cov) ? e_fd : 32'h0);
    chk("commit_error", commit_error, m_err);
    if (rst_n) begin
      if (commit_valid) begin
        e_j = -1;
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].c) begin
            e_j = i;
            break;
          end
        end
        if (e_j >= 0 && q[e_j].t == commit_ticket) begin
          e_ent   = q[e_j];
          e_ent.c = 1'b1;
          q[e_j]  = e_ent;
        end else begin
          m_err = 1'b1;
        end
      end
      if (e_drain) void'(q.pop_front());
      if (flush_valid) begin
        while (q.size() > 0 && !q[q.size()-1].c) void'(q.pop_back());
      end else if (store_valid) begin
        if (e_pacc) q.push_back('{a: store_address, d: store_data, u: store_microop,
                                  t: store_ticket, c: 1'b0});
        else m_err = 1'b1;
      end
    end
  end

  task automatic idle();
    store_valid = 0; store_address = 0; store_data = 0; store_microop = 0; store_ticket = 0;
    commit_valid = 0; commit_ticket = 0; flush_valid = 0; frw_address = 0; frw_microop = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [4:0] u,
                      input logic [2:0] t);
    store_valid = 1; store_address = a; store_data = d; store_microop = u; store_ticket = t;
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] u);
    frw_address = a; frw_microop = u;
  endtask

  task automatic commit(input logic [2:0] t);
    commit_valid = 1; commit_ticket = t;
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 0; cache_wb_ready = 0;
    mid();
    nxt();
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    cache_wb_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mid();
    chk("rst_full", sb_full, 0);
    chk("rst_err", commit_error, 0);
    chk("rst_wbv", cache_writeback_valid, 0);

    // Word store forwarded to a word load the next cycle
    nxt(); push(32'h100, 32'hDEADBEEF, SW, 0);
    nxt(); load(32'h100, LW); mid();
    chk("t1_valid", frw_valid, 1);
    chk("t1_data", frw_data, 32'hDEADBEEF);
    chk("t1_stall", frw_stall, 0);

    // Byte store: partial overlap stalls, disjoint byte misses, exact byte hits
    do_reset();
    nxt(); push(32'h101, 32'hAA, SB, 0);
    nxt(); load(32'h100, LW); mid();
    chk("t2_lw_stall", frw_stall, 1);
    chk("t2_lw_valid", frw_valid, 0);
    nxt(); load(32'h103, LB); mid();
    chk("t2_lb_stall", frw_stall, 0);
    chk("t2_lb_valid", frw_valid, 0);
    nxt(); load(32'h101, LBU); mid();
    chk("t2_lbu_valid", frw_valid, 1);
    chk("t2_lbu_data", frw_data, 32'h000000AA);
    nxt(); load(32'h100, LH); mid();
    chk("t2_lh_stall", frw_stall, 1);

    // Youngest of two same-address stores wins, including the same-cycle push
    do_reset();
    nxt(); push(32'h200, 32'h11, SW, 0);
    nxt(); push(32'h200, 32'h22, SW, 1); load(32'h200, LW); mid();
    chk("t3_same_cycle", frw_data, 32'h22);
    nxt(); load(32'h200, LW); mid();
    chk("t3_next_cycle", frw_data, 32'h22);

    // Fill, overflow push, in-order drain, push accepted while full and draining
    do_reset();
    cache_wb_ready = 1;
    for (int i = 0; i < 4; i++) begin
      nxt(); push(32'h300 + 4 * i, i + 1, SW, 3'(i));
    end
    nxt(); mid();
    chk("t4_full", sb_full, 1);
    chk("t4_wbv_before", cache_writeback_valid, 0);
    nxt(); push(32'h320, 32'h99, SW, 4); commit(0); mid();
    nxt(); commit(1); push(32'h310, 32'h5, SW, 4); mid();
    chk("t4_overflow_err", commit_error, 1);
    chk("t4_wb0_addr", cache_wb_address, 32'h300);
    chk("t4_wb0_data", cache_wb_data, 32'h1);
    nxt(); mid();
    chk("t4_wb1_addr", cache_wb_address, 32'h304);
    chk("t4_full_after_swap", sb_full, 1);
    nxt(); mid();
    chk("t4_wbv_idle", cache_writeback_valid, 0);

    // Flush with same-cycle commit keeps one entry; new pushes wrap around
    do_reset();
    nxt(); push(32'h400, 32'hA0, SW, 0);
    nxt(); push(32'h404, 32'hA1, SW, 1);
    nxt(); push(32'h408, 32'hA2, SW, 2);
    nxt(); commit(0); flush_valid = 1; push(32'h40C, 32'hA3, SW, 3); mid();
    nxt(); load(32'h404, LW); mid();
    chk("t5_flushed_miss", frw_valid, 0);
    chk("t5_flushed_stall", frw_stall, 0);
    chk("t5_kept_wb", cache_wb_address, 32'h400);
    chk("t5_not_full", sb_full, 0);
    nxt(); push(32'h500, 32'hB1, SW, 1); load(32'h40C, LW); mid();
    chk("t5_flush_push_ignored", frw_valid, 0);
    nxt(); push(32'h504, 32'hB2, SW, 2);
    nxt(); push(32'h508, 32'hB3, SW, 3);
    nxt(); mid();
    chk("t5_refull", sb_full, 1);
    nxt(); cache_wb_ready = 1; commit(1); mid();
    chk("t5_wb_400", cache_wb_address, 32'h400);
    nxt(); commit(2); mid();
    chk("t5_wb_500", cache_wb_address, 32'h500);
    nxt(); commit(3); push(32'h50C, 32'hB4, SW, 4); mid();
    chk("t5_wb_504", cache_wb_address, 32'h504);
    nxt(); mid();
    chk("t5_wb_508", cache_wb_address, 32'h508);
    nxt(); load(32'h50C, LW); mid();
    chk("t5_wrap_fwd", frw_data, 32'hB4);
    nxt(); commit(4);
    nxt(); mid();
    chk("t5_wb_50c", cache_wb_address, 32'h50C);
    nxt(); mid();
    chk("t5_empty", cache_writeback_valid, 0);

    // Reset in the middle of a stalled drain, then bad commits
    do_reset();
    nxt(); push(32'h600, 32'hC0, SW, 5);
    nxt(); push(32'h604, 32'hC1, SH, 6);
    nxt(); commit(5);
    nxt(); mid();
    chk("t6_hold_a", cache_wb_address, 32'h600);
    nxt(); mid();
    chk("t6_hold_b", cache_wb_data, 32'hC0);
    nxt(); rst_n = 0; load(32'h604, LH); mid();
    chk("t6_rst_wbv", cache_writeback_valid, 0);
    chk("t6_rst_addr", cache_wb_address, 0);
    chk("t6_rst_fwd", frw_valid, 0);
    chk("t6_rst_err", commit_error, 0);
    nxt(); rst_n = 1; commit(3);
    nxt(); mid();
    chk("t6_empty_commit_err", commit_error, 1);
    do_reset();
    nxt(); push(32'h700, 32'hD0, SW, 2);
    nxt(); commit(5);
    nxt(); mid();
    chk("t6_ticket_err", commit_error, 1);
    chk("t6_ticket_no_wb", cache_writeback_valid, 0);

    nxt();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Post-execute store queue that sits between the load/store unit, the ROB and the data cache. It accepts executed stores from the LSU's second stage in program order and holds them until the ROB commits them. It then drains committed stores one per handshake into the data cache write port, and meanwhile answers the LSU's same-cycle store-to-load forwarding queries. Flushes discard every uncommitted entry; committed entries always reach the cache.

## Interface
- DATA_WIDTH, 32, store data bits
- ADDR_BITS, 32, address bits
- MICROOP, 5, microoperation bits
- ROB_TICKET, 3, ROB ticket bits
- DEPTH, 4, entries; power of two, at least 2
---
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- store_valid  in  1  push executed store
- store_address  in  ADDR_BITS  store byte address
- store_data  in  DATA_WIDTH  store data, unshifted, low-aligned
- store_microop  in  MICROOP  00110 SW, 00111 SH, 01000 SB
- store_ticket  in  ROB_TICKET  ROB ticket of the store
- sb_full  out  1  all DEPTH entries occupied
- commit_valid  in  1  ROB retires the oldest uncommitted store
- commit_ticket  in  ROB_TICKET  ticket being retired
- flush_valid  in  1  pipeline flush
- frw_address  in  ADDR_BITS  load byte address
- frw_microop  in  MICROOP  load op: 00001 LW, 00010 LH, 00011 LHU, 00100 LB, 00101 LBU
- frw_data  out  DATA_WIDTH  forwarded store data
- frw_valid  out  1  load fully satisfied by a buffered store
- frw_stall  out  1  partial overlap; the load must retry
- cache_writeback_valid  out  1  committed head presented to cache (also blocks LSU cache port)
- cache_wb_ready  in  1  cache accepts the write
- cache_wb_address, cache_wb_data, cache_wb_microop  out  head entry fields
- commit_error  out  1  sticky: commit_ticket mismatch or commit with nothing to commit

## Operation
- Circular FIFO: head pointer, tail pointer, count (0..DEPTH) and commit pointer. Per-entry fields: valid, committed, addr, data, microop, ticket.
- Push: `store_valid` writes the entry at tail with committed=0, then tail++. A push while `sb_full`=1 with no same-cycle drain is dropped and sets `commit_error`.
- Commit: `commit_valid` marks the entry at the commit pointer committed, then commit pointer++. If that entry's ticket ≠ `commit_ticket`, or no uncommitted entry exists, `commit_error` is set and nothing changes.
- Drain: `cache_writeback_valid` = head valid AND head committed. On `cache_wb_ready`, the head is freed and head++.
- Flush: every uncommitted entry is invalidated; tail and commit pointer are set to the first free slot after the last committed entry. A commit in the flush cycle is applied before the flush. A push in the flush cycle is ignored.
- Forwarding (combinational): byte mask = 4'b1111 (W), 2 bytes at addr[1] (H), 1 byte at addr[1:0] (B).
  - Candidates are all valid entries plus the incoming push, which counts as youngest.
  - Only the youngest candidate whose word address (addr[ADDR_BITS-1:2]) and byte mask overlap the load is considered.
  - frw_valid=1 when its address equals `frw_address` exactly and its mask covers the load mask. frw_data = that entry's data.
  - Any other overlap gives frw_stall=1, frw_valid=0.
  - No overlap gives frw_valid=frw_stall=0, frw_data=0.
- Wrap-around: pointers are log2(DEPTH) bits, modulo DEPTH; count disambiguates full from empty.

## Timing
- Reset values: all entries invalid, pointers=0, count=0, sb_full=0, cache_writeback_valid=0, frw_valid=0, frw_stall=0, frw_data=0, cache_wb_*=0, commit_error=0.
- Forwarding has zero latency and includes same-cycle pushes.
- A pushed store can be committed in the cycle after the push at the earliest. A committed store is presented to the cache in the cycle after commit.
- Push, commit and drain may all occur in one cycle. count' = count + push − drain.
- If the full buffer drains its head in the same cycle, the simultaneous push is accepted.
- cache_wb_* fields are held stable while valid and not ready.

## Structure
- A shared package holds the microop localparams (store and load encodings), the sb_entry_t struct, and a function mask_of(microop, addr[1:0]) returning 4 bits.
- One sub-module, sb_forward_match: a purely combinational youngest-overlap priority search over DEPTH+1 candidates, ordered by age relative to head.

## Test plan
- Push SW 0x100/0xDEADBEEF; LW 0x100 in the next cycle → frw_valid=1, frw_data=0xDEADBEEF.
- Push SB 0x101/0xAA; LW 0x100 → frw_stall=1, frw_valid=0. Then LB 0x103 → neither flag set.
- Push SW then SW to the same address (0x11, 0x22) → LW returns 0x22. LW issued in the cycle of the second push also returns 0x22.
- Fill 4 entries → sb_full=1. Commit 2, cache_wb_ready=1 → 2 writebacks in order, cache_writeback_valid stays 0 until each commit.
- 3 entries, commit 1, flush → count=1; only the committed store is written back; new pushes reuse the freed slots with correct wrap-around.
- Reset asserted mid-drain (cache_wb_ready=0) → all outputs return to reset values immediately; commit with a wrong ticket afterwards → commit_error=1.
